// File: rtl/pixel_plane_writer_if.sv
// Packed {b, g, r} pixel stream feeding pixel_plane_writer (no backpressure).
// QUAN_BITS sets bits per channel and defaults to 8.
`ifndef QUAN_BITS
`define QUAN_BITS 8
`endif

interface pixel_plane_writer_if;
  logic [3*`QUAN_BITS-1:0] i_pix;
  logic                    i_pix_valid;

  modport master (output i_pix, output i_pix_valid);
  modport slave  (input  i_pix, input  i_pix_valid);
endinterface

// File: rtl/pixel_plane_writer.sv
// Scatters a packed {b, g, r} pixel stream into three planar write ports at row*IMG_W+col.
// Optional PIX_ZERO_POINT_EN converts each channel from unsigned to signed by flipping its MSB.
`ifndef QUAN_BITS
`define QUAN_BITS 8
`endif

module pixel_plane_writer #(
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32,
  parameter int ADDR_W = 10
) (
  input  logic                  s_clk,
  input  logic                  s_rst_n,
  input  logic                  i_start,
  pixel_plane_writer_if.slave   pix_if,
  output logic                  o_we,
  output logic [ADDR_W-1:0]     o_addr,
  output logic [`QUAN_BITS-1:0] o_r,
  output logic [`QUAN_BITS-1:0] o_g,
  output logic [`QUAN_BITS-1:0] o_b,
  output logic                  o_busy,
  output logic                  o_frame_done,
  output logic                  o_drop
);

  localparam int QB    = `QUAN_BITS;
  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            r_state;
  logic [COL_W-1:0]  r_col;
  logic [ROW_W-1:0]  r_row;
  logic [ADDR_W-1:0] r_addr;

  logic          w_valid;
  logic [QB-1:0] w_r, w_g, w_b;
  logic          w_col_last, w_row_last;

  function automatic logic [QB-1:0] conv(input logic [QB-1:0] c);
`ifdef PIX_ZERO_POINT_EN
    conv = {~c[QB-1], c[QB-2:0]};
`else
    conv = c;
`endif
  endfunction

  assign w_valid    = pix_if.i_pix_valid;
  assign w_r        = conv(pix_if.i_pix[QB-1:0]);
  assign w_g        = conv(pix_if.i_pix[2*QB-1:QB]);
  assign w_b        = conv(pix_if.i_pix[3*QB-1:2*QB]);
  assign w_col_last = (r_col == COL_W'(IMG_W - 1));
  assign w_row_last = (r_row == ROW_W'(IMG_H - 1));

  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      r_state      <= IDLE;
      r_col        <= '0;
      r_row        <= '0;
      r_addr       <= '0;
      o_we         <= 1'b0;
      o_addr       <= '0;
      o_r          <= '0;
      o_g          <= '0;
      o_b          <= '0;
      o_busy       <= 1'b0;
      o_frame_done <= 1'b0;
      o_drop       <= 1'b0;
    end else begin
      o_we         <= 1'b0;
      o_frame_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_state <= RUN;
            r_col   <= '0;
            r_row   <= '0;
            r_addr  <= '0;
            o_busy  <= 1'b1;
            // a pixel arriving with the start pulse is still outside the frame
            o_drop  <= w_valid;
          end else if (w_valid) begin
            o_drop <= 1'b1;
          end
        end
        RUN: begin
          if (w_valid) begin
            o_we   <= 1'b1;
            o_addr <= r_addr;
            o_r    <= w_r;
            o_g    <= w_g;
            o_b    <= w_b;
            r_addr <= r_addr + 1'b1;
            if (w_col_last) begin
              r_col <= '0;
              r_row <= r_row + 1'b1;
              if (w_row_last) r_state <= DONE;
            end else begin
              r_col <= r_col + 1'b1;
            end
          end
        end
        DONE: begin
          o_frame_done <= 1'b1;
          o_busy       <= 1'b0;
          r_state      <= IDLE;
          if (w_valid) o_drop <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
